// File: rtl/m74hc_div4_if.sv
// Start/busy/done handshake between the core sequencer (master) and the
// 4-bit restoring divider (slave).
interface m74hc_div4_if;
  logic       start_i;
  logic [3:0] dividend_i;
  logic [3:0] divisor_i;
  logic [3:0] quo_o;
  logic [3:0] rem_o;
  logic       dz_o;
  logic       busy_o;
  logic       done_o;

  modport master (
    output start_i, dividend_i, divisor_i,
    input  quo_o, rem_o, dz_o, busy_o, done_o
  );

  modport slave (
    input  start_i, dividend_i, divisor_i,
    output quo_o, rem_o, dz_o, busy_o, done_o
  );
endinterface

// File: rtl/m74hc_div4.sv
// Sequential 4-bit unsigned restoring divider: one quotient bit per clock,
// subtraction done as Rs + ~D + 1 with the carry-out acting as "no borrow".
module m74hc_div4 (
  input  logic         clk_i,
  input  logic         rst_n_i,
  m74hc_div4_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] q_r, d_r;
  logic [4:0] r_r;
  logic [1:0] cnt;
  logic       dz_r;
  logic [3:0] quo_r, rem_r;
  logic       dz_o_r;

  logic [4:0] rs;
  logic [5:0] sum;
  logic       ge;
  logic [4:0] r_nxt;
  logic [3:0] q_nxt;

  // Carry out of the 6-bit sum is set exactly when Rs >= D.
  always_comb begin
    rs    = {r_r[3:0], q_r[3]};
    sum   = {1'b0, rs} + {1'b0, 1'b1, ~d_r} + 6'd1;
    ge    = sum[5];
    r_nxt = ge ? sum[4:0] : rs;
    q_nxt = {q_r[2:0], ge};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start_i) state_nxt = S_CALC;
      S_CALC:  if (cnt == 2'd3) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_r    <= '0;
      r_r    <= '0;
      d_r    <= '0;
      cnt    <= '0;
      dz_r   <= 1'b0;
      quo_r  <= '0;
      rem_r  <= '0;
      dz_o_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.start_i) begin
          d_r  <= bus.divisor_i;
          q_r  <= bus.dividend_i;
          r_r  <= '0;
          cnt  <= '0;
          dz_r <= (bus.divisor_i == 4'd0);
        end
        S_CALC: begin
          r_r <= r_nxt;
          q_r <= q_nxt;
          cnt <= cnt + 2'd1;
          // Results are captured from the final step so they are valid in DONE.
          if (cnt == 2'd3) begin
            quo_r  <= q_nxt;
            rem_r  <= r_nxt[3:0];
            dz_o_r <= dz_r;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quo_o  = quo_r;
  assign bus.rem_o  = rem_r;
  assign bus.dz_o   = dz_o_r;
  assign bus.busy_o = (state != S_IDLE);
  assign bus.done_o = (state == S_DONE);

endmodule
